// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit with architectural HI/LO registers.
//
// Sits beside the single-cycle ALU in EX. The decoder issues a one-cycle
// `start` with `op` and operands. MULT/MULTU/DIV/DIVU run DATA_WIDTH radix-2
// steps (CALC), then one sign-fix/commit cycle (FIX). `done` pulses in the
// cycle after FIX, with HI/LO already updated. MTHI/MTLO write HI/LO directly
// from IDLE without stalling.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   start      issue strobe, only sampled in IDLE
//   op         0/7 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//   operand_1  multiplicand / dividend / MTHI-MTLO source
//   operand_2  multiplier / divisor
//   cancel     flush; aborts an in-flight operation, suppresses a start in IDLE
//   busy       high in CALC and FIX (registered state decode)
//   stall      combinational pipeline hold
//   done       one-cycle pulse after commit (registered)
//   hi, lo     HI and LO registers
//
// Handshake: `start` is a single-cycle valid with no ready; the pipeline must
// not issue while `stall` is high, so any `start` seen outside IDLE is ignored.
// The FSM state is held in `state` (type state_t) for checkers to bind to.
module ex_muldiv #(
  parameter int DATA_WIDTH = 32,
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
  state_t state, state_next;

  logic [2:0]           op_r;
  logic [W-1:0]         opnd;    // multiplicand (mul) or divisor (div) magnitude
  logic [W-1:0]         a_raw;   // raw dividend, returned in HI on divide by zero
  logic                 neg_a, neg_b, div0;
  logic [2*W-1:0]       acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [CNT_WIDTH-1:0] cnt;

  // Issue decode
  logic         is_md, issue_md, in_signed, in_mul, in_neg_a, in_neg_b;
  logic [W-1:0] in_mag_a, in_mag_b;

  always_comb begin
    is_md     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    issue_md  = start && (state == S_IDLE) && is_md && !cancel;
    in_signed = (op == OP_MULT) || (op == OP_DIV);
    in_mul    = (op == OP_MULT) || (op == OP_MULTU);
    in_neg_a  = in_signed && operand_1[W-1];
    in_neg_b  = in_signed && operand_2[W-1];
    // The most-negative value's magnitude 2^(W-1) is still representable unsigned.
    in_mag_a  = in_neg_a ? (-operand_1) : operand_1;
    in_mag_b  = in_neg_b ? (-operand_2) : operand_2;
  end

  assign busy  = (state != S_IDLE);
  assign stall = busy || issue_md;

  // One radix-2 iteration
  logic         r_mul, last;
  logic [W:0]   mul_sum, div_shift;
  logic         div_ge;
  logic [W-1:0] div_rem;
  logic [2*W-1:0] step_next;

  always_comb begin
    r_mul     = (op_r == OP_MULT) || (op_r == OP_MULTU);
    last      = (cnt == CNT_WIDTH'(W - 1));
    // Shift-add: add multiplicand to the upper half when the current LSB is set,
    // then shift the whole accumulator right; the carry lands in bit 2W-1.
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    // Restoring divide: bring the next dividend bit into the remainder.
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_rem   = div_shift[W-1:0] - opnd;
    if (r_mul) step_next = {mul_sum, acc[W-1:1]};
    else       step_next = {(div_ge ? div_rem : div_shift[W-1:0]), acc[W-2:0], div_ge};
  end

  // Sign correction for the FIX commit
  logic [2*W-1:0] prod;
  logic [W-1:0]   res_hi, res_lo;

  always_comb begin
    prod = (neg_a ^ neg_b) ? (-acc) : acc;
    if (r_mul) begin
      res_hi = prod[2*W-1:W];
      res_lo = prod[W-1:0];
    end else if (div0) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_lo = (neg_a ^ neg_b) ? (-acc[W-1:0]) : acc[W-1:0];
      res_hi = neg_a ? (-acc[2*W-1:W]) : acc[2*W-1:W];
    end
  end

  // FSM
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (issue_md) state_next = S_CALC;
      S_CALC: begin
        if (cancel)    state_next = S_IDLE;
        else if (last) state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_r  <= '0;
      opnd  <= '0;
      a_raw <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      div0  <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue_md) begin
            op_r  <= op;
            opnd  <= in_mul ? in_mag_a : in_mag_b;
            acc   <= {{W{1'b0}}, (in_mul ? in_mag_b : in_mag_a)};
            a_raw <= operand_1;
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
            div0  <= (operand_2 == '0);
            cnt   <= '0;
          end else if (start && !cancel && op == OP_MTHI) begin
            hi <= operand_1;
          end else if (start && !cancel && op == OP_MTLO) begin
            lo <= operand_1;
          end
        end
        S_CALC: begin
          if (!cancel) begin
            acc <= step_next;
            cnt <= cnt + 1'b1;
          end
        end
        S_FIX: begin
          // Cancel wins over the commit.
          if (!cancel) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv (DATA_WIDTH = 32).
module tb_ex_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] operand_1, operand_2;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_1(operand_1), .operand_2(operand_2), .cancel(cancel),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Issue an op (optionally in the current cycle, for back-to-back) and wait
  // for done, checking latency, stall profile and HI/LO. Returns in the done cycle.
  task automatic run_md(input string name, input bit sync, input logic [2:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int k;
    int n_stall;
    bit got;
    if (sync) @(negedge clk);
    start = 1'b1; op = o; operand_1 = a; operand_2 = b;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL %s issue_stall: got %b expected 1", name, stall); end
    n_stall = 1; got = 0; k = 0;
    while (!got && k < 60) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      #1;
      if (done) got = 1;
      else if (stall) n_stall++;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL %s done_timeout: got no done expected done", name); end
    n_checks++;
    if (k != W + 2) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, k, W + 2); end
    n_checks++;
    if (n_stall != W + 2) begin n_fail++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, n_stall, W + 2); end
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL %s done_stall: got %b expected 0", name, stall); end
    n_checks++;
    if (hi !== exp_hi) begin n_fail++; $display("FAIL %s hi: got %h expected %h", name, hi, exp_hi); end
    n_checks++;
    if (lo !== exp_lo) begin n_fail++; $display("FAIL %s lo: got %h expected %h", name, lo, exp_lo); end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; operand_1 = '0; operand_2 = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, done, stall} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, stall}); end
    n_checks++;
    if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    rst = 1'b1;
  endtask

  task automatic test_multu();
    run_md("multu_max", 1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_mult();
    run_md("mult_neg3x5", 1, 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("mult_minxmin", 1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
  endtask

  task automatic test_div();
    run_md("div_neg7by2", 1, 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_minbym1", 1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_md("divu_5by0", 1, 3'd4, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_md("div_neg5by0", 1, 3'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_md("divu_100by7", 1, 3'd4, 32'd100, 32'd7, 32'd2, 32'd14);
  endtask

  task automatic test_mthi_cancel();
    int n_done;
    @(negedge clk);
    start = 1'b1; op = 3'd5; operand_1 = 32'h1234; #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: got %b expected 0", stall); end
    @(negedge clk);
    op = 3'd6; operand_1 = 32'h5678; #1;
    n_checks++;
    if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_hi: got %h expected 00001234", hi); end
    @(negedge clk);
    start = 1'b0; #1;
    n_checks++;
    if (lo !== 32'h5678 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mtlo_lo: got lo=%h busy=%b done=%b expected 00005678/0/0", lo, busy, done);
    end
    // DIVU 100/7 cancelled in CALC cycle 10
    @(negedge clk);
    start = 1'b1; op = 3'd4; operand_1 = 32'd100; operand_2 = 32'd7;
    n_done = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) cancel = 1'b1;
      #1;
      if (done) n_done++;
    end
    @(negedge clk);
    cancel = 1'b0; #1;
    n_checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL cancel_calc_busy: got busy=%b stall=%b expected 0/0", busy, stall); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin n_fail++; $display("FAIL cancel_calc_done: got %0d expected 0", n_done); end
    n_checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin n_fail++; $display("FAIL cancel_calc_hilo: got %h/%h expected 00001234/00005678", hi, lo); end
  endtask

  task automatic test_cancel_fix();
    int n_done;
    @(negedge clk);
    start = 1'b1; op = 3'd2; operand_1 = 32'd2; operand_2 = 32'd3;
    n_done = 0;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == W + 1) cancel = 1'b1;
      #1;
      if (done) n_done++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cancel = 1'b0; #1;
      if (done) n_done++;
    end
    n_checks++;
    if (n_done != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL cancel_fix_done: got done=%0d busy=%b expected 0/0", n_done, busy); end
    n_checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin n_fail++; $display("FAIL cancel_fix_hilo: got %h/%h expected 00001234/00005678", hi, lo); end
  endtask

  task automatic test_cancel_idle();
    @(negedge clk);
    start = 1'b1; op = 3'd1; operand_1 = 32'd3; operand_2 = 32'd3; cancel = 1'b1; #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_stall: got %b expected 0", stall); end
    @(negedge clk);
    op = 3'd5; operand_1 = 32'hDEAD; #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_busy: got %b expected 0", busy); end
    @(negedge clk);
    cancel = 1'b0; op = 3'd7; #1;
    n_checks++;
    if (hi !== 32'h1234 || stall !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_mthi: got hi=%h stall=%b expected 00001234/0", hi, stall); end
    @(negedge clk);
    start = 1'b0; #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL nop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    run_md("b2b_first", 1, 3'd2, 32'd7, 32'd9, 32'd0, 32'd63);
    run_md("b2b_second", 0, 3'd2, 32'd2, 32'd3, 32'd0, 32'd6);
  endtask

  task automatic test_reset_calc();
    @(negedge clk);
    start = 1'b1; op = 3'd5; operand_1 = 32'hAAAA;
    @(negedge clk);
    op = 3'd2; operand_1 = 32'd3; operand_2 = 32'd3;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({busy, done, stall} !== 3'b000) begin n_fail++; $display("FAIL reset_calc_ctrl: got %b expected 000", {busy, done, stall}); end
    n_checks++;
    if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_calc_hilo: got %h expected 0", {hi, lo}); end
    rst = 1'b1;
    run_md("after_reset", 1, 3'd2, 32'd3, 32'd4, 32'd0, 32'd12);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_mthi_cancel();
    test_cancel_fix();
    test_cancel_idle();
    test_back_to_back();
    test_reset_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
